joybus_device: RTL

//  Device (controller) end of the N64 JOYBUS: receives a host command byte on the

---
 rtl/joybus_pkg.sv | 32 +++
 rtl/joybus_dev_tx.sv | 68 ++++++
 rtl/joybus_device.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/joybus_pkg.sv
// JOYBUS device shared types and constants.
// Timing constants are in microseconds; modules scale them by CYC_PER_US.
package joybus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RX_LOW,
    RX_HIGH,
    RX_STOP,
    TURN,
    TX_BIT,
    TX_STOP,
    SKIP
  } Dev_state_t;

  localparam logic [7:0]  CMD_STATUS = 8'h00;
  localparam logic [7:0]  CMD_POLL   = 8'h01;
  localparam logic [7:0]  CMD_RESET  = 8'hFF;
  localparam logic [23:0] DEV_ID     = 24'h050002;

  localparam int BIT_US      = 4;
  localparam int ONE_LOW_US  = 1;
  localparam int ZERO_LOW_US = 3;
  localparam int SMP_US      = 2;
  localparam int RX_STOP_US  = 3;
  localparam int TX_STOP_US  = 2;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/joybus_dev_tx.sv
// JOYBUS device bit-cell transmitter.
// Shifts out len bits from the MSB of word, one 4 us cell per bit.
module joybus_dev_tx
  import joybus_pkg::*;
#(
  parameter int CYC_PER_US = 25
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [5:0]  len,
  input  logic [31:0] word,
  output logic        oe,
  output logic        done
);

  localparam int CELL = BIT_US * CYC_PER_US;
  localparam int CW   = $clog2(CELL);

  localparam logic [CW-1:0] T_END  = CW'(CELL - 1);
  localparam logic [CW-1:0] T_ONE  = CW'(ONE_LOW_US * CYC_PER_US);
  localparam logic [CW-1:0] T_ZERO = CW'(ZERO_LOW_US * CYC_PER_US);

  logic [31:0]   sh;
  logic [5:0]    cnt;
  logic [CW-1:0] tmr;
  logic          act;
  logic [CW-1:0] low;

  assign low = sh[31] ? T_ONE : T_ZERO;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh   <= '0;
      cnt  <= '0;
      tmr  <= '0;
      act  <= 1'b0;
      oe   <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        sh  <= word;
        cnt <= len;
        tmr <= '0;
        act <= 1'b1;
        oe  <= 1'b1;
      end else if (act) begin
        if (tmr == T_END) begin
          tmr <= '0;
          if (cnt == 6'd1) begin
            act  <= 1'b0;
            oe   <= 1'b0;
            done <= 1'b1;
          end else begin
            sh  <= {sh[30:0], 1'b0};
            cnt <= cnt - 6'd1;
            oe  <= 1'b1;
          end
        end else begin
          tmr <= tmr + CW'(1);
          oe  <= ((tmr + CW'(1)) < low);
        end
      end
    end
  end

endmodule

// File: rtl/joybus_device.sv
// JOYBUS device (controller) end: receives a host command byte
// and answers with the device ID or a 32-bit button report.
module joybus_device
  import joybus_pkg::*;
#(
  parameter int CYC_PER_US = 25,
  parameter int TURN_US    = 2,
  parameter int TMO_US     = 5,
  parameter int IDLE_US    = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        jb_in,
  output logic        jb_oe,
  input  logic [31:0] btn_data,
  output logic [7:0]  cmd_byte,
  output logic        cmd_vld,
  output logic        rx_err,
  output logic        busy
);

  localparam int TW =
    $clog2(max_of(max_of(IDLE_US, TMO_US), BIT_US) * CYC_PER_US) + 1;

  localparam logic [TW-1:0] T_SMP  = TW'(SMP_US * CYC_PER_US);
  localparam logic [TW-1:0] T_TMO  = TW'(TMO_US * CYC_PER_US);
  localparam logic [TW-1:0] T_RSTP = TW'(RX_STOP_US * CYC_PER_US);
  localparam logic [TW-1:0] T_TURN = TW'(TURN_US * CYC_PER_US - 1);
  localparam logic [TW-1:0] T_TSTP = TW'(TX_STOP_US * CYC_PER_US);
  localparam logic [TW-1:0] T_IDLE = TW'(IDLE_US * CYC_PER_US - 1);

  Dev_state_t    state;
  logic [TW-1:0] timer;
  logic [5:0]    bit_cnt;
  logic [7:0]    shreg;
  logic [31:0]   tx_word;
  logic [5:0]    tx_len;
  logic          tx_start;
  logic          tx_oe;
  logic          tx_done;
  logic          stop_oe;

  logic s1, s2, lq;
  logic fall, rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      lq <= 1'b1;
    end else begin
      s1 <= jb_in;
      s2 <= s1;
      lq <= s2;
    end
  end

  assign fall  = lq & ~s2;
  assign rise  = ~lq & s2;
  assign busy  = (state != IDLE);
  assign jb_oe = tx_oe | stop_oe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      timer    <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      tx_word  <= '0;
      tx_len   <= '0;
      tx_start <= 1'b0;
      stop_oe  <= 1'b0;
      cmd_byte <= '0;
      cmd_vld  <= 1'b0;
      rx_err   <= 1'b0;
    end else begin
      cmd_vld  <= 1'b0;
      rx_err   <= 1'b0;
      tx_start <= 1'b0;
      unique case (state)
        IDLE: begin
          if (fall) begin
            state   <= RX_LOW;
            bit_cnt <= '0;
            timer   <= '0;
          end
        end
        // rise before the 2 us sample point means the line read high
        RX_LOW: begin
          if (rise) begin
            shreg   <= {shreg[6:0], (timer <= T_SMP)};
            bit_cnt <= bit_cnt + 6'd1;
            timer   <= '0;
            state   <= RX_HIGH;
          end else if (timer >= T_TMO) begin
            rx_err <= 1'b1;
            timer  <= '0;
            state  <= SKIP;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        RX_HIGH: begin
          if (fall) begin
            timer <= '0;
            state <= (bit_cnt == 6'd8) ? RX_STOP : RX_LOW;
          end else if (timer >= T_TMO) begin
            rx_err <= 1'b1;
            timer  <= '0;
            state  <= SKIP;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        RX_STOP: begin
          if (rise) begin
            cmd_vld  <= 1'b1;
            cmd_byte <= shreg;
            timer    <= '0;
            unique case (1'b1)
              (shreg == CMD_STATUS),
              (shreg == CMD_RESET): begin
                tx_word <= {DEV_ID, 8'h00};
                tx_len  <= 6'd24;
                state   <= TURN;
              end
              (shreg == CMD_POLL): begin
                tx_word <= btn_data;
                tx_len  <= 6'd32;
                state   <= TURN;
              end
              default: state <= SKIP;
            endcase
          end else if (timer >= T_RSTP) begin
            rx_err <= 1'b1;
            timer  <= '0;
            state  <= SKIP;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        TURN: begin
          if (timer == T_TURN) begin
            tx_start <= 1'b1;
            state    <= TX_BIT;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        TX_BIT: begin
          if (tx_done) begin
            stop_oe <= 1'b1;
            timer   <= '0;
            state   <= TX_STOP;
          end
        end
        TX_STOP: begin
          if (timer < T_TSTP) begin
            timer <= timer + TW'(1);
            if (timer == T_TSTP - TW'(1)) stop_oe <= 1'b0;
          end else if (s2) begin
            state <= IDLE;
          end
        end
        SKIP: begin
          if (!s2) timer <= '0;
          else if (timer == T_IDLE) state <= IDLE;
          else timer <= timer + TW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

  joybus_dev_tx #(
    .CYC_PER_US(CYC_PER_US)
  ) u_tx (
    .clk  (clk),
    .rst_n(rst_n),
    .start(tx_start),
    .len  (tx_len),
    .word (tx_word),
    .oe   (tx_oe),
    .done (tx_done)
  );

endmodule
